// File: rtl/present_encoder.sv
// Iterative PRESENT-80 encryptor: one round per clock, 31 rounds plus final
// key whitening, ciphertext registered and held until the next block completes.
module present_encoder #(
   parameter int unsigned NR_ROUNDS   = 32,
   parameter logic [79:0] INITIAL_KEY = 80'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  pl,
   input  logic [79:0] in_text,
   output logic [63:0] text,
   output logic        done,
   output logic        busy
);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e      fsm_q, fsm_d;
   logic [79:0] key_q, key_d;
   logic [79:0] rk_q, rk_d;
   logic [63:0] st_q, st_d;
   logic [5:0]  round_q, round_d;
   logic [63:0] text_q, text_d;
   logic        done_q, done_d;
   logic        last_round;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int unsigned j = 0; j < 16; j++)
         y[6'(4*j) +: 4] = sbox4(x[6'(4*j) +: 4]);
      return y;
   endfunction

   // bit i lands at (16*i) mod 63; bit 63 is fixed
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      y     = '0;
      y[63] = x[63];
      for (int unsigned i = 0; i < 63; i++)
         y[6'((16*i) % 63)] = x[6'(i)];
      return y;
   endfunction

   function automatic logic [79:0] rk_upd(input logic [79:0] k, input logic [4:0] r);
      logic [79:0] t;
      t          = {k[18:0], k[79:19]};
      t[79:76]   = sbox4(t[79:76]);
      t[19:15]   = t[19:15] ^ r;
      return t;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= S_IDLE;
         key_q   <= INITIAL_KEY;
         rk_q    <= '0;
         st_q    <= '0;
         round_q <= '0;
         text_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         key_q   <= key_d;
         rk_q    <= rk_d;
         st_q    <= st_d;
         round_q <= round_d;
         text_q  <= text_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      last_round = (round_q == 6'(NR_ROUNDS));
      fsm_d      = fsm_q;
      case (fsm_q)
         S_IDLE:  if (!pl[1] && pl[0]) fsm_d = S_RUN;
         S_RUN:   if (last_round)      fsm_d = S_IDLE;
         default: fsm_d = S_IDLE;
      endcase
   end

   always_comb begin
      key_d   = key_q;
      rk_d    = rk_q;
      st_d    = st_q;
      round_d = round_q;
      text_d  = text_q;
      done_d  = 1'b0;
      if (fsm_q == S_IDLE) begin
         if (pl[1]) begin
            key_d = in_text;
         end else if (pl[0]) begin
            st_d    = in_text[63:0];
            rk_d    = key_q;
            round_d = 6'd1;
         end
      end else if (last_round) begin
         text_d  = st_q ^ rk_q[79:16];
         done_d  = 1'b1;
         round_d = '0;
      end else begin
         st_d    = p_layer(s_layer(st_q ^ rk_q[79:16]));
         rk_d    = rk_upd(rk_q, round_q[4:0]);
         round_d = round_q + 6'd1;
      end
   end

   assign text = text_q;
   assign done = done_q;
   assign busy = (fsm_q == S_RUN);

endmodule

// File: tb/tb_present_encoder.sv
// Bench for present_encoder: known-answer table, randomized blocks against a
// reference cipher, and hand-written back-to-back / busy / reset sequences.
module tb_present_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  pl = 2'b00;
   logic [79:0] in_text = '0;
   logic [63:0] text;
   logic        done, busy;

   int n_vec = 0;
   int n_err = 0;

   present_encoder #(.NR_ROUNDS(32), .INITIAL_KEY(80'h0)) dut (
      .clk(clk), .reset(reset), .pl(pl), .in_text(in_text),
      .text(text), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [79:0] key;
      logic        reload;
      logic [63:0] pt;
      logic [63:0] ct;
   } vec_t;

   logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference cipher: precompute the whole round-key list, then apply rounds.
   function automatic logic [63:0] ref_present(input logic [79:0] key, input logic [63:0] pt);
      logic [79:0] k;
      logic [79:0] rks [33];
      logic [63:0] s, t;
      k = key;
      for (int r = 1; r <= 32; r++) begin
         rks[r] = k;
         k = (k << 61) | (k >> 19);
         k[79:76] = SB[k[79:76]];
         k[19:15] = k[19:15] ^ 5'(r);
      end
      s = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ rks[r][79:16];
         for (int j = 0; j < 16; j++) s[6'(4*j) +: 4] = SB[s[6'(4*j) +: 4]];
         t = '0;
         for (int b = 0; b < 64; b++) t[(b == 63) ? 6'd63 : 6'((b * 16) % 63)] = s[6'(b)];
         s = t;
      end
      return s ^ rks[32][79:16];
   endfunction

   task automatic load_key(input logic [79:0] k);
      pl = 2'b10; in_text = k;
      @(posedge clk); #1;
      pl = 2'b00; in_text = '0;
   endtask

   task automatic start_block(input logic [63:0] pt);
      pl = 2'b01; in_text = {16'h0, pt};
      @(posedge clk); #1;
      pl = 2'b00; in_text = '0;
   endtask

   // Waits up to 100 cycles for done; optionally drives pl=11 garbage for the first cycles.
   task automatic wait_done(input int garbage, output logic [63:0] ct, output int lat);
      lat = -1;
      ct  = '0;
      for (int n = 1; n <= 100; n++) begin
         if (n <= garbage) begin
            pl = 2'b11; in_text = {16'($urandom), $urandom, $urandom};
         end else begin
            pl = 2'b00; in_text = '0;
         end
         @(posedge clk); #1;
         if (done) begin
            lat = n; ct = text;
            break;
         end
      end
      pl = 2'b00; in_text = '0;
   endtask

   task automatic run_block(input logic [63:0] pt, input int garbage, output logic [63:0] ct, output int lat);
      start_block(pt);
      wait_done(garbage, ct, lat);
   endtask

   task automatic watch_quiet(input string name, input int cycles);
      int hits;
      hits = 0;
      for (int n = 0; n < cycles; n++) begin
         @(posedge clk); #1;
         if (done || busy) hits++;
      end
      check(name, 80'(hits), 80'd0);
   endtask

   vec_t tbl [4];

   initial begin
      logic [63:0] ct, pt;
      logic [79:0] k;
      int lat;

      tbl[0] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0,                64'hE72C46C0F5945049};
      tbl[1] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2};
      tbl[2] = '{80'h0,                        1'b1, 64'h0,                64'h5579C1387B228445};
      tbl[3] = '{80'h0,                        1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hA112FFC72F68417B};

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_text", 80'(text), 80'h0);
      check("reset_done", 80'(done), 80'h0);
      check("reset_busy", 80'(busy), 80'h0);

      // INITIAL_KEY is used without any key load
      start_block(64'h0);
      check("start_busy", 80'(busy), 80'h1);
      wait_done(0, ct, lat);
      check("init_key_ct", 80'(ct), 80'h5579C1387B228445);
      check("init_key_lat", 80'(lat), 80'd32);
      @(posedge clk); #1;
      check("done_one_cycle", 80'(done), 80'h0);
      check("text_held", 80'(text), 80'h5579C1387B228445);

      foreach (tbl[i]) begin
         if (tbl[i].reload) load_key(tbl[i].key);
         run_block(tbl[i].pt, 0, ct, lat);
         check($sformatf("kat%0d_ct", i), 80'(ct), 80'(tbl[i].ct));
         check($sformatf("kat%0d_lat", i), 80'(lat), 80'd32);
      end

      // back-to-back: next block issued in the done cycle
      load_key(80'h0);
      run_block(64'h0, 0, ct, lat);
      check("b2b_first_ct", 80'(ct), 80'h5579C1387B228445);
      start_block(64'hFFFFFFFFFFFFFFFF);
      check("b2b_done_clear", 80'(done), 80'h0);
      check("b2b_busy", 80'(busy), 80'h1);
      wait_done(0, ct, lat);
      check("b2b_second_ct", 80'(ct), 80'hA112FFC72F68417B);
      check("b2b_spacing", 80'(lat + 1), 80'd33);

      // pl=11 with garbage while busy must not disturb block or key
      k  = {16'($urandom), $urandom, $urandom};
      pt = {$urandom, $urandom};
      load_key(k);
      run_block(pt, 20, ct, lat);
      check("garbage_ct", 80'(ct), 80'(ref_present(k, pt)));
      check("garbage_lat", 80'(lat), 80'd32);
      pt = {$urandom, $urandom};
      run_block(pt, 0, ct, lat);
      check("garbage_key_kept", 80'(ct), 80'(ref_present(k, pt)));

      // pl=11 while idle: key loads only
      k = {16'($urandom), $urandom, $urandom};
      pl = 2'b11; in_text = k;
      @(posedge clk); #1;
      pl = 2'b00; in_text = '0;
      check("pl11_busy", 80'(busy), 80'h0);
      watch_quiet("pl11_no_activity", 40);
      pt = {$urandom, $urandom};
      run_block(pt, 0, ct, lat);
      check("pl11_key_loaded", 80'(ct), 80'(ref_present(k, pt)));

      for (int i = 0; i < 16; i++) begin
         if (i == 0 || $urandom_range(0, 2) != 0) begin
            k = {16'($urandom), $urandom, $urandom};
            load_key(k);
         end
         pt = {$urandom, $urandom};
         run_block(pt, 0, ct, lat);
         check($sformatf("rand%0d_ct", i), 80'(ct), 80'(ref_present(k, pt)));
      end

      // asynchronous reset mid-block abandons it and restores INITIAL_KEY
      load_key(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
      start_block(64'h0);
      repeat (15) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_text", 80'(text), 80'h0);
      check("rst_mid_done", 80'(done), 80'h0);
      check("rst_mid_busy", 80'(busy), 80'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      watch_quiet("rst_no_done", 40);
      run_block(64'h0, 0, ct, lat);
      check("rst_fresh_ct", 80'(ct), 80'h5579C1387B228445);
      check("rst_fresh_lat", 80'(lat), 80'd32);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
